// File: rtl/snitch_ssr_data_mover.sv
// SSR data mover: turns the address generator's stream into TCDM loads/stores and
// buffers data between TCDM and the lane in a credit-managed FIFO with read repetition.
module snitch_ssr_data_mover #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned RptWidth  = 4,
    parameter int unsigned Depth     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [RptWidth-1:0]    cfg_rep_i,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic                   mem_write_i,
    input  logic                   mem_valid_i,
    output logic                   mem_ready_o,
    output logic [AddrWidth-1:0]   tcdm_req_addr_o,
    output logic                   tcdm_req_write_o,
    output logic [DataWidth-1:0]   tcdm_req_data_o,
    output logic [DataWidth/8-1:0] tcdm_req_strb_o,
    output logic                   tcdm_req_valid_o,
    input  logic                   tcdm_req_ready_i,
    input  logic [DataWidth-1:0]   tcdm_rsp_data_i,
    input  logic                   tcdm_rsp_valid_i,
    output logic [DataWidth-1:0]   lane_rdata_o,
    output logic                   lane_rvalid_o,
    input  logic                   lane_rready_i,
    input  logic [DataWidth-1:0]   lane_wdata_i,
    input  logic                   lane_wvalid_i,
    output logic                   lane_wready_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntW      = $clog2(Depth + 1);
    localparam int unsigned PtrW      = $clog2(Depth);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high.
    // valid never depends on ready, and once raised it holds (with its payload) until
    // the transfer, as long as the upstream side keeps its own valid and payload.

    logic                 mode_q;
    logic [CntW-1:0]      fifo_cnt;
    logic [CntW-1:0]      out_cnt;
    logic [RptWidth-1:0]  rep_q;
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [DataWidth-1:0] mem_q [Depth];
    logic                 rst_drain_q;

    logic                 mode_match;
    logic                 mode_switch;
    logic                 credit_ok;
    logic                 grant;
    logic                 rsp_accept;
    logic                 lane_rhs;
    logic                 lane_whs;
    logic                 push;
    logic                 pop;
    logic [DataWidth-1:0] push_data;
    logic [CntW:0]        in_flight;

    assign mode_match  = (mem_write_i == mode_q);
    assign mode_switch = mem_valid_i & ~mode_match & (fifo_cnt == '0) & (out_cnt == '0);

    assign in_flight = {1'b0, fifo_cnt} + {1'b0, out_cnt};
    assign credit_ok = in_flight < {1'b0, DepthCnt};

    always_comb begin
        tcdm_req_valid_o = 1'b0;
        if (mem_valid_i && mode_match) begin
            if (mode_q == MODE_WRITE) tcdm_req_valid_o = (fifo_cnt != '0);
            else                      tcdm_req_valid_o = credit_ok;
        end
    end

    assign grant            = tcdm_req_valid_o & tcdm_req_ready_i;
    assign mem_ready_o      = grant;
    assign tcdm_req_addr_o  = mem_addr_i;
    assign tcdm_req_write_o = mode_q;
    assign tcdm_req_data_o  = mem_q[rd_ptr_q];
    assign tcdm_req_strb_o  = {StrbWidth{mode_q}};

    assign lane_rvalid_o = (mode_q == MODE_READ) & (fifo_cnt != '0);
    assign lane_rdata_o  = mem_q[rd_ptr_q];
    assign lane_wready_o = (mode_q == MODE_WRITE) & (fifo_cnt < DepthCnt);

    // Responses with nothing outstanding are stale (e.g. issued before a reset) and dropped.
    assign rsp_accept = tcdm_rsp_valid_i & (mode_q == MODE_READ) & (out_cnt != '0);
    assign lane_rhs   = lane_rvalid_o & lane_rready_i;
    assign lane_whs   = lane_wvalid_i & lane_wready_o;

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        push_data = tcdm_rsp_data_i;
        if (mode_q == MODE_WRITE) begin
            push      = lane_whs;
            pop       = grant;
            push_data = lane_wdata_i;
        end else begin
            push = rsp_accept;
            pop  = lane_rhs & (rep_q == cfg_rep_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= MODE_READ;
        end else if (mode_switch) begin
            mode_q <= mem_write_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_cnt <= '0;
        end else if (push && !pop) begin
            fifo_cnt <= fifo_cnt + CntW'(1);
        end else if (pop && !push) begin
            fifo_cnt <= fifo_cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt <= '0;
        end else begin
            case ({grant & (mode_q == MODE_READ), rsp_accept})
                2'b10:   out_cnt <= out_cnt + CntW'(1);
                2'b01:   out_cnt <= out_cnt - CntW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_q <= '0;
        end else if (lane_rhs) begin
            rep_q <= (rep_q == cfg_rep_i) ? '0 : rep_q + RptWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // Set from reset until the first load issues: late responses are legal in that window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_drain_q <= 1'b1;
        end else if (grant && (mode_q == MODE_READ)) begin
            rst_drain_q <= 1'b0;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(push && !pop && fifo_cnt == DepthCnt))
                else $error("data mover: FIFO overflow");
            assert (!(pop && fifo_cnt == '0))
                else $error("data mover: FIFO underflow");
            assert (!(grant && mode_q == MODE_READ && !rsp_accept && out_cnt == DepthCnt))
                else $error("data mover: outstanding counter overflow");
            assert (!(tcdm_rsp_valid_i && out_cnt == '0 && !rst_drain_q))
                else $error("data mover: response without outstanding load");
            assert (!(lane_rhs && rep_q > cfg_rep_i))
                else $error("data mover: repetition counter overrun");
        end
    end

endmodule

// File: tb/tb_snitch_ssr_data_mover.sv
// Directed bench for snitch_ssr_data_mover: loads, credit stall, repetition,
// store stream, mode switch and asynchronous reset with stale responses.
module tb_snitch_ssr_data_mover;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  cfg_rep_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic        mem_write_i = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic        mem_ready_o;
    logic [31:0] tcdm_req_addr_o;
    logic        tcdm_req_write_o;
    logic [63:0] tcdm_req_data_o;
    logic [7:0]  tcdm_req_strb_o;
    logic        tcdm_req_valid_o;
    logic        tcdm_req_ready_i = 1'b0;
    logic [63:0] tcdm_rsp_data_i = '0;
    logic        tcdm_rsp_valid_i = 1'b0;
    logic [63:0] lane_rdata_o;
    logic        lane_rvalid_o;
    logic        lane_rready_i = 1'b0;
    logic [63:0] lane_wdata_i = '0;
    logic        lane_wvalid_i = 1'b0;
    logic        lane_wready_o;

    int checks = 0;
    int errors = 0;

    snitch_ssr_data_mover #(
        .DataWidth(64), .AddrWidth(32), .RptWidth(4), .Depth(4)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .cfg_rep_i        (cfg_rep_i),
        .mem_addr_i       (mem_addr_i),
        .mem_write_i      (mem_write_i),
        .mem_valid_i      (mem_valid_i),
        .mem_ready_o      (mem_ready_o),
        .tcdm_req_addr_o  (tcdm_req_addr_o),
        .tcdm_req_write_o (tcdm_req_write_o),
        .tcdm_req_data_o  (tcdm_req_data_o),
        .tcdm_req_strb_o  (tcdm_req_strb_o),
        .tcdm_req_valid_o (tcdm_req_valid_o),
        .tcdm_req_ready_i (tcdm_req_ready_i),
        .tcdm_rsp_data_i  (tcdm_rsp_data_i),
        .tcdm_rsp_valid_i (tcdm_rsp_valid_i),
        .lane_rdata_o     (lane_rdata_o),
        .lane_rvalid_o    (lane_rvalid_o),
        .lane_rready_i    (lane_rready_i),
        .lane_wdata_i     (lane_wdata_i),
        .lane_wvalid_i    (lane_wvalid_i),
        .lane_wready_o    (lane_wready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Load issued and answered one cycle later, leaving one more FIFO entry.
    task automatic load_one(input logic [31:0] addr, input logic [63:0] data);
        mem_valid_i = 1'b1; mem_write_i = 1'b0; mem_addr_i = addr;
        #1 chk1("load_grant", mem_ready_o, 1'b1);
        tick();
        mem_valid_i = 1'b0;
        tcdm_rsp_valid_i = 1'b1; tcdm_rsp_data_i = data;
        tick();
        tcdm_rsp_valid_i = 1'b0;
    endtask

    logic [63:0] rep_exp [3];

    initial begin
        rep_exp[0] = 64'hA0A0; rep_exp[1] = 64'hB0B0; rep_exp[2] = 64'hC0C0;

        // Reset state
        #1;
        chk1("rst_req_valid", tcdm_req_valid_o, 1'b0);
        chk1("rst_rvalid", lane_rvalid_o, 1'b0);
        chk1("rst_mem_ready", mem_ready_o, 1'b0);
        chk1("rst_wready", lane_wready_o, 1'b0);
        @(negedge clk_i) rst_ni = 1'b1;
        tick();
        chk1("post_rst_wready", lane_wready_o, 1'b0);

        // Single load, rep 0
        mem_valid_i = 1'b1; mem_addr_i = 32'h100; tcdm_req_ready_i = 1'b1;
        #1;
        chk1("s1_req_valid", tcdm_req_valid_o, 1'b1);
        chk1("s1_mem_ready", mem_ready_o, 1'b1);
        chk("s1_addr", 64'(tcdm_req_addr_o), 64'h100);
        chk("s1_strb", 64'(tcdm_req_strb_o), 64'h0);
        chk1("s1_write", tcdm_req_write_o, 1'b0);
        tick();
        mem_valid_i = 1'b0;
        #1;
        chk("s1_out1", 64'(dut.out_cnt), 64'd1);
        tick();
        tcdm_rsp_valid_i = 1'b1; tcdm_rsp_data_i = 64'hDEADBEEF;
        #1 chk1("s1_no_bypass", lane_rvalid_o, 1'b0);
        tick();
        tcdm_rsp_valid_i = 1'b0;
        #1;
        chk1("s1_rvalid", lane_rvalid_o, 1'b1);
        chk("s1_rdata", lane_rdata_o, 64'hDEADBEEF);
        chk("s1_out0", 64'(dut.out_cnt), 64'd0);
        lane_rready_i = 1'b1;
        tick();
        lane_rready_i = 1'b0;
        #1;
        chk1("s1_empty", lane_rvalid_o, 1'b0);
        chk("s1_fifo0", 64'(dut.fifo_cnt), 64'd0);

        // Credit stall
        for (int i = 0; i < 4; i++) load_one(32'h200 + 32'(i * 8), 64'h1000 + 64'(i));
        mem_valid_i = 1'b1; mem_addr_i = 32'h220;
        #1 chk1("cr_stall_a", tcdm_req_valid_o, 1'b0);
        chk1("cr_stall_ready", mem_ready_o, 1'b0);
        tick();
        #1 chk1("cr_stall_b", tcdm_req_valid_o, 1'b0);
        lane_rready_i = 1'b1;
        #1 chk("cr_head", lane_rdata_o, 64'h1000);
        chk1("cr_stall_c", tcdm_req_valid_o, 1'b0);
        tick();
        lane_rready_i = 1'b0;
        #1 chk1("cr_issue", tcdm_req_valid_o, 1'b1);
        chk1("cr_issue_ready", mem_ready_o, 1'b1);
        tick();
        mem_valid_i = 1'b0;
        tcdm_rsp_valid_i = 1'b1; tcdm_rsp_data_i = 64'h1004;
        tick();
        tcdm_rsp_valid_i = 1'b0;
        lane_rready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("cr_drain", lane_rdata_o, 64'h1001 + 64'(i));
            tick();
        end
        lane_rready_i = 1'b0;
        #1 chk1("cr_empty", lane_rvalid_o, 1'b0);
        chk("cr_out0", 64'(dut.out_cnt), 64'd0);

        // Repetition, rep = 2
        cfg_rep_i = 4'd2;
        for (int i = 0; i < 3; i++) load_one(32'h280 + 32'(i * 8), rep_exp[i]);
        lane_rready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1 chk("rep_data", lane_rdata_o, rep_exp[i / 3]);
            tick();
        end
        lane_rready_i = 1'b0;
        #1 chk1("rep_empty", lane_rvalid_o, 1'b0);
        cfg_rep_i = 4'd0;

        // Store stream
        mem_valid_i = 1'b1; mem_write_i = 1'b1; mem_addr_i = 32'h300; tcdm_req_ready_i = 1'b0;
        #1 chk1("st_mismatch", tcdm_req_valid_o, 1'b0);
        tick();
        #1;
        chk1("st_mode", dut.mode_q, 1'b1);
        chk1("st_wready", lane_wready_o, 1'b1);
        chk1("st_nodata", tcdm_req_valid_o, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            lane_wvalid_i = 1'b1; lane_wdata_i = 64'(i);
            tick();
        end
        lane_wvalid_i = 1'b0;
        #1;
        chk1("st_valid", tcdm_req_valid_o, 1'b1);
        chk1("st_noready", mem_ready_o, 1'b0);
        chk("st_strb", 64'(tcdm_req_strb_o), 64'hFF);
        chk("st_head", tcdm_req_data_o, 64'h1);
        chk1("st_write", tcdm_req_write_o, 1'b1);
        lane_wvalid_i = 1'b1; lane_wdata_i = 64'h4;
        #1 chk1("st_wready4", lane_wready_o, 1'b1);
        tick();
        lane_wdata_i = 64'h5;
        #1 chk1("st_full", lane_wready_o, 1'b0);
        tick();
        lane_wvalid_i = 1'b0;
        tcdm_req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_addr_i = 32'h300 + 32'(i * 8);
            #1 chk("st_order", tcdm_req_data_o, 64'(i + 1));
            chk1("st_grant", mem_ready_o, 1'b1);
            tick();
        end
        #1 chk1("st_drained", tcdm_req_valid_o, 1'b0);

        // Mode switch: write -> read, then read with response pending -> write
        mem_write_i = 1'b0; mem_addr_i = 32'h400;
        #1 chk1("ms_stall_r", tcdm_req_valid_o, 1'b0);
        tick();
        #1 chk1("ms_read_go", mem_ready_o, 1'b1);
        tick();
        mem_write_i = 1'b1; mem_addr_i = 32'h500;
        #1 chk1("ms_stall_w", tcdm_req_valid_o, 1'b0);
        chk1("ms_stall_w_rdy", mem_ready_o, 1'b0);
        tick();
        tcdm_rsp_valid_i = 1'b1; tcdm_rsp_data_i = 64'h5555;
        #1 chk1("ms_stall_w2", tcdm_req_valid_o, 1'b0);
        tick();
        tcdm_rsp_valid_i = 1'b0;
        #1;
        chk1("ms_mode_r", dut.mode_q, 1'b0);
        chk("ms_rdata", lane_rdata_o, 64'h5555);
        tick();
        #1 chk1("ms_mode_held", dut.mode_q, 1'b0);
        lane_rready_i = 1'b1;
        tick();
        lane_rready_i = 1'b0;
        #1 chk1("ms_mode_pre", dut.mode_q, 1'b0);
        tick();
        #1;
        chk1("ms_mode_w", dut.mode_q, 1'b1);
        chk1("ms_nodata", tcdm_req_valid_o, 1'b0);
        lane_wvalid_i = 1'b1; lane_wdata_i = 64'h77;
        tick();
        lane_wvalid_i = 1'b0;
        #1;
        chk1("ms_store", mem_ready_o, 1'b1);
        chk("ms_store_data", tcdm_req_data_o, 64'h77);
        tick();
        mem_valid_i = 1'b0;

        // Async reset with 2 loads outstanding and 1 FIFO entry
        mem_valid_i = 1'b1; mem_write_i = 1'b0; mem_addr_i = 32'h600;
        tick();
        #1 chk1("ar_read_mode", tcdm_req_valid_o, 1'b1);
        tick();
        mem_addr_i = 32'h608;
        tick();
        mem_addr_i = 32'h610;
        tcdm_rsp_valid_i = 1'b1; tcdm_rsp_data_i = 64'h1111;
        tick();
        mem_valid_i = 1'b0; tcdm_rsp_valid_i = 1'b0;
        #1;
        chk("ar_out2", 64'(dut.out_cnt), 64'd2);
        chk("ar_fifo1", 64'(dut.fifo_cnt), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk1("ar_rvalid", lane_rvalid_o, 1'b0);
        chk1("ar_req_valid", tcdm_req_valid_o, 1'b0);
        chk1("ar_mem_ready", mem_ready_o, 1'b0);
        chk1("ar_wready", lane_wready_o, 1'b0);
        chk("ar_out0", 64'(dut.out_cnt), 64'd0);
        @(negedge clk_i) rst_ni = 1'b1;
        tick();
        tcdm_rsp_valid_i = 1'b1; tcdm_rsp_data_i = 64'h2222;
        tick();
        tick();
        tcdm_rsp_valid_i = 1'b0;
        #1;
        chk1("ar_late_rvalid", lane_rvalid_o, 1'b0);
        chk("ar_late_fifo", 64'(dut.fifo_cnt), 64'd0);
        chk("ar_late_out", 64'(dut.out_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snitch_ssr_data_mover.md
Name: snitch_ssr_data_mover

Overview:
- Downstream stage of the SSR address generator. Consumes its address/write stream and issues the matching TCDM loads and stores.
- Buffers data in a credit-managed FIFO between TCDM and the register lane. Applies per-element read repetition.
- One instance per SSR lane, placed between the address generator and the core-facing lane port.

Parameters:
- DataWidth, 64, TCDM and lane data width in bits; must be a power of two and at least 16.
- AddrWidth, 32, TCDM byte address width.
- RptWidth, 4, width of the repetition count.
- Depth, 4, data FIFO entries, which also bounds outstanding loads; must be at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_rep_i  in  RptWidth  extra lane reads per element (0 = each element read once); stable while a job runs
- mem_addr_i  in  AddrWidth  byte address from address generator
- mem_write_i  in  1  1 = store, 0 = load
- mem_valid_i  in  1  address valid
- mem_ready_o  out  1  address accepted
- tcdm_req_addr_o  out  AddrWidth  request address (mem_addr_i passed through)
- tcdm_req_write_o  out  1  request is a store
- tcdm_req_data_o  out  DataWidth  store data (FIFO head)
- tcdm_req_strb_o  out  DataWidth/8  byte strobe; all ones on stores, all zeros on loads
- tcdm_req_valid_o  out  1  request valid
- tcdm_req_ready_i  in  1  request granted
- tcdm_rsp_data_i  in  DataWidth  load response data
- tcdm_rsp_valid_i  in  1  load response valid; in order, one per granted load, latency 1 cycle or more
- lane_rdata_o  out  DataWidth  read data to core
- lane_rvalid_o  out  1  read data valid
- lane_rready_i  in  1  core consumes read data
- lane_wdata_i  in  DataWidth  write data from core
- lane_wvalid_i  in  1  write data valid
- lane_wready_o  out  1  write data accepted

Behaviour:
- State:
  - FIFO of Depth entries, with count fifo_cnt of width clog2(Depth+1).
  - outstanding-load counter out_cnt of the same width.
  - repetition counter rep_q of width RptWidth.
  - mode register mode_q: 0 = read, 1 = write.
- Reset: all state cleared and mode_q = read. Outputs during and right after reset:
  - tcdm_req_valid_o = 0, lane_rvalid_o = 0, mem_ready_o = 0 (no address presented).
  - lane_wready_o = 0, since mode is read.
- Reset mid-operation drops FIFO contents and outstanding counts. Responses arriving after reset release are ignored because out_cnt = 0.
- Mode switch:
  - A presented address whose write flag differs from mode_q is stalled (req valid and mem_ready_o low).
  - It stays stalled until fifo_cnt = 0 and out_cnt = 0. Then mode_q takes mem_write_i on the next cycle and the request proceeds the cycle after.
- Read mode:
  - credits = Depth - fifo_cnt - out_cnt. Issue is allowed when credits > 0.
  - tcdm_req_valid_o = mem_valid_i & mode match & credits > 0.
  - mem_ready_o = tcdm_req_valid_o & tcdm_req_ready_i; the grant cycle is the address handshake.
  - On grant, out_cnt increments.
  - On tcdm_rsp_valid_i, data is pushed to the FIFO and out_cnt decrements. A simultaneous grant and response nets to no change in out_cnt.
  - A response with out_cnt = 0 is a protocol error and is flagged by assertion.
- Read lane side:
  - lane_rvalid_o = fifo_cnt > 0; lane_rdata_o = FIFO head, registered storage with no response-to-lane bypass. Minimum latency is response cycle +1.
  - On each lane handshake: if rep_q == cfg_rep_i, pop the FIFO and clear rep_q; otherwise increment rep_q.
  - A push and a pop in the same cycle leave fifo_cnt unchanged.
- Write mode:
  - lane_wready_o = fifo_cnt < Depth; a lane handshake pushes lane_wdata_i.
  - tcdm_req_valid_o = mem_valid_i & mode match & fifo_cnt > 0; tcdm_req_data_o = FIFO head.
  - On grant: pop the FIFO and complete the address handshake. No response is expected; cfg_rep_i is ignored.
  - A push and a pop in the same cycle leave fifo_cnt unchanged. With the FIFO full, lane_wready_o = 0.
- Handshake rules:
  - tcdm_req_valid_o never depends on tcdm_req_ready_i.
  - Once asserted, the request stays stable until granted, provided upstream holds mem_valid_i and its payload.
- Arithmetic: all counters are unsigned and cannot wrap; assertions on overflow and underflow.

Test Plan:
- Single load, rep = 0: address 0x100, grant same cycle, response 0xDEADBEEF two cycles later → lane_rvalid_o rises the cycle after the response. One lane handshake empties the FIFO; out_cnt returns to 0.
- Credit stall, Depth = 4, lane_rready_i = 0: issue 4 loads with all responses returned → 5th address sees tcdm_req_valid_o = 0. One lane pop → 5th issued the next cycle.
- Repetition, cfg_rep_i = 2: three elements A, B, C → lane sees A,A,A,B,B,B,C,C,C over 9 handshakes.
- Store stream: lane pushes 0x1, 0x2, 0x3 while tcdm_req_ready_i = 0 → strobe all ones, data order 0x1, 0x2, 0x3 on grants. A 5th push while 4 are held gives lane_wready_o = 0.
- Mode switch: a read with a response pending, then a write address → write stalls until the response is popped. mode_q flips, then the store issues.
- Async reset asserted with 2 loads outstanding and 1 FIFO entry → all outputs 0 immediately. After release, late responses are ignored and fifo_cnt stays 0.
